// File: rtl/booth_pkg.sv
// Shared types and sizing constants for the sequential radix-4 Booth multiplier.
package booth_pkg;

  localparam int A_W  = 16;
  localparam int B_W  = 16;
  localparam int P_W  = A_W + B_W;
  localparam int ROWS = B_W / 2;
  localparam int K_W  = $clog2(ROWS);

  localparam logic [K_W-1:0] LAST_ROW = K_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/booth_pp_row.sv
// Radix-4 Booth row generator: encodes one multiplier triplet and selects the
// matching 17-bit partial-product row plus its complement-correction bit.
module booth_pp_row
  import booth_pkg::*;
(
  input  logic [2:0]     triplet,
  input  logic [A_W-1:0] a,
  output logic [A_W:0]   p,
  output logic           neg
);

  logic [A_W:0] a_x1;
  logic [A_W:0] a_x2;

  assign a_x1 = {a[A_W-1], a};
  assign a_x2 = {a, 1'b0};

  // Negative rows are emitted inverted; the +1 arrives through neg.
  always_comb begin
    p   = '0;
    neg = 1'b0;
    case (triplet)
      3'b000: p = '0;
      3'b001,
      3'b010: p = a_x1;
      3'b011: p = a_x2;
      3'b100: begin
        p   = ~a_x2;
        neg = 1'b1;
      end
      3'b101,
      3'b110: begin
        p   = ~a_x1;
        neg = 1'b1;
      end
      3'b111: begin
        p   = '1;
        neg = 1'b1;
      end
      default: begin
        p   = '0;
        neg = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative 16x16 signed radix-4 Booth multiplier, one row per clock.
// Optional early termination when the remaining rows are zero: BOOTH_EARLY_TERM_EN.
module booth_seq_mult
  import booth_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] product,
  output logic           busy
);

  state_t         state;
  logic [A_W-1:0] a_reg;
  logic [B_W:0]   window;
  logic [K_W-1:0] k;
  logic [P_W-1:0] acc;

  logic [A_W:0]   row_p;
  logic           row_neg;
  logic [P_W-1:0] row_term;
  logic [P_W-1:0] acc_next;
  logic [B_W:0]   window_next;
  logic           finish;

  booth_pp_row u_row (
    .triplet (window[2:0]),
    .a       (a_reg),
    .p       (row_p),
    .neg     (row_neg)
  );

  assign row_term    = ({{(P_W-A_W-1){row_p[A_W]}}, row_p}
                       + {{(P_W-1){1'b0}}, row_neg}) << {k, 1'b0};
  assign acc_next    = acc + row_term;
  assign window_next = {{2{window[B_W]}}, window[B_W:2]};

`ifdef BOOTH_EARLY_TERM_EN
  // A uniform window after this row means every later row is zero, so stop now.
  assign finish = (k == LAST_ROW) || (window_next == '0) || (window_next == '1);
`else
  assign finish = (k == LAST_ROW);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      a_reg     <= '0;
      window    <= '0;
      k         <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            window   <= {b, 1'b0};
            acc      <= '0;
            k        <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc    <= acc_next;
          window <= window_next;
          k      <= k + 1'b1;
          if (finish) begin
            state     <= DONE;
            product   <= acc_next;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
- Iterative 16x16 signed radix-4 Booth multiplier; sits downstream of the radix-4 partial-product row logic.
- Consumes one 17-bit Booth partial-product row plus its neg (complement-correction) bit per cycle and accumulates all rows into a 32-bit two's-complement product.
- Valid/ready handshake on both input and output; one operation in flight.

Parameters:
- A_W, 16, multiplicand width (fixed by row format; other values unsupported).
- B_W, 16, multiplier width (even; row count = B_W/2).
- P_W, 32, product width = A_W+B_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  16  signed multiplicand.
- b  input  16  signed multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  32  signed a*b.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync deassert via clk): state=IDLE; in_ready=1; out_valid=0; busy=0; product=0; accumulator, row counter and operand registers cleared.
- States: IDLE -> RUN on in_valid&in_ready (latch a; latch {b,1'b0} as 17-bit window register; acc=0; k=0). RUN -> DONE after the final row (k=7). DONE -> IDLE on out_valid&out_ready.
- in_ready = (state==IDLE); in_valid in RUN/DONE is ignored, operands are not re-sampled.
- RUN cycle k (0..7): triplet = window[2:0] = {b[2k+1],b[2k],b[2k-1]}, b[-1]=0. Row generator yields P[16:0], neg. acc <= acc + (sext32(P) << 2k) + (neg << 2k), modulo 2^32. Window shifts right by 2 (arithmetic); k increments.
- Encoding: 000/111 -> +0 (111 gives P=all ones, neg=1, net zero); 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A. Negative rows are bitwise-inverted with neg=1.
- Latency: accept at cycle T; RUN T+1..T+8; out_valid=1 and product=final acc from T+9.
- product and out_valid are registered and held stable while out_valid&!out_ready (unlimited backpressure).
- Earliest next accept: cycle after the output handshake (in_ready high in IDLE only; no same-cycle output handshake and input accept).
- Result is exact for all operand pairs, including -32768*-32768 = 0x40000000.
- rst_n low mid-RUN or mid-DONE: operation discarded, all outputs return to reset values immediately; no partial product is ever presented.

Optional Feature:
- Macro BOOTH_EARLY_TERM_EN.
- Defined: at the start of each RUN cycle, if the remaining window (all 17 bits) is all-0 or all-1, all remaining rows are zero: skip accumulation and go to DONE that cycle. Latency is 1..8 RUN cycles; b=0 or b=-1 gives out_valid at T+2.
- Undefined: exactly 8 RUN cycles always; no comparator logic is present.

Decomposition:
- Package booth_pkg: state enum {IDLE,RUN,DONE}; constants A_W=16, B_W=16, P_W=32, ROWS=8; row-count width localparam.
- Sub-module booth_pp_row: combinational triplet+A -> {neg, P[16:0]} (encoder plus row mux).
- Top contains the FSM, window shift register, counter, accumulator and output register.

Test Plan:
- a=3, b=5; out_ready=1 -> product=0x0000000F, out_valid at T+9, one cycle wide.
- a=-32768, b=-32768 -> product=0x40000000; a=32767, b=-32768 -> 0xC0008000.
- a=-1, b=1 -> 0xFFFFFFFF; a=1234, b=-1 -> 0xFFFFFB2E (-1234); checks the 111 (-0) row.
- Backpressure: a=7, b=-9, out_ready=0 for 5 cycles -> product=0xFFFFFFC1 held stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
- Assert rst_n=0 at RUN cycle 4 of a=100, b=200 -> out_valid=0, product=0, in_ready=1 immediately; the next op a=100, b=200 -> 0x00004E20.
- BOOTH_EARLY_TERM_EN: b=0 -> product=0, out_valid at T+2; b=2 -> out_valid at T+3; random 10k pairs match the reference model a*b.
